uart_tx_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single 8N1 UART transmitter between up to 8 byte-stream requesters (status reporter, debug echo, LED/command responder, …). It sits between the requesters and the transmitter, issues one start pulse per byte, and tracks the transmitter's busy flag. Message locking keeps multi-byte messages contiguous on the line, and a hold timeout stops a stalled owner from blocking the port.

---
 rtl/uart_tx_arbiter.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one 8N1 UART transmitter between
// NUM_REQ byte-stream requesters, with message locking and a hold timeout.
module uart_tx_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_TIMEOUT = 12000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           tx_byte,
    output logic                 tx_start,
    input  logic                 tx_busy,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 timeout
);

    localparam int unsigned NR = NUM_REQ;
    localparam int IW = $clog2(NUM_REQ);
    localparam int CW = $clog2(HOLD_TIMEOUT + 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_TIMEOUT - 1);
    localparam logic [IW-1:0] IDX_MAX   = IW'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACK,
        S_DRAIN,
        S_HOLD
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        ptr_q, ptr_d;
    logic [IW-1:0]        owner_q, owner_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [7:0]           tx_byte_q, tx_byte_d;
    logic                 last_q, last_d;
    logic                 tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
    logic                 timeout_q, timeout_d;
    logic [CW-1:0]        hold_cnt_q, hold_cnt_d;

    logic                 found;
    logic [IW-1:0]        sel_idx;
    logic [IW-1:0]        cand_idx;
    logic                 capture;
    logic [IW-1:0]        cap_idx;
    logic [IW-1:0]        nxt_ptr;

    // Round-robin search: first valid requester starting at ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        cand_idx = '0;
        for (int unsigned k = 0; k < NR; k++) begin
            cand_idx = IW'((32'(ptr_q) + k) % NR);
            if (!found && req_valid[cand_idx]) begin
                found   = 1'b1;
                sel_idx = cand_idx;
            end
        end
    end

    // Pointer value used when the current owner releases its lock.
    always_comb begin
        nxt_ptr = (owner_q == IDX_MAX) ? '0 : owner_q + 1'b1;
    end

    // Next-state and output computation for the arbitration sequencer.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;
        grant_d     = grant_q;
        tx_byte_d   = tx_byte_q;
        last_d      = last_q;
        tx_start_d  = 1'b0;
        req_ready_d = '0;
        timeout_d   = 1'b0;
        hold_cnt_d  = hold_cnt_q;
        capture     = 1'b0;
        cap_idx     = sel_idx;

        case (state_q)
            S_IDLE: begin
                if (!tx_busy && found) begin
                    capture = 1'b1;
                    cap_idx = sel_idx;
                end
            end
            S_ACK: begin
                if (tx_busy) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!tx_busy) begin
                    if (last_q) begin
                        grant_d = '0;
                        ptr_d   = nxt_ptr;
                        state_d = S_IDLE;
                    end else begin
                        hold_cnt_d = '0;
                        state_d    = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                // Owner valid wins over the terminal count.
                if (req_valid[owner_q]) begin
                    capture = 1'b1;
                    cap_idx = owner_q;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    timeout_d  = 1'b1;
                    grant_d    = '0;
                    ptr_d      = nxt_ptr;
                    hold_cnt_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (capture) begin
            owner_d     = cap_idx;
            grant_d     = NUM_REQ'(1) << cap_idx;
            req_ready_d = NUM_REQ'(1) << cap_idx;
            tx_byte_d   = req_data[{cap_idx, 3'b000} +: 8];
            last_d      = req_last[cap_idx];
            tx_start_d  = 1'b1;
            state_d     = S_ACK;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            grant_q     <= '0;
            tx_byte_q   <= '0;
            last_q      <= 1'b0;
            tx_start_q  <= 1'b0;
            req_ready_q <= '0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            grant_q     <= grant_d;
            tx_byte_q   <= tx_byte_d;
            last_q      <= last_d;
            tx_start_q  <= tx_start_d;
            req_ready_q <= req_ready_d;
            timeout_q   <= timeout_d;
            hold_cnt_q  <= hold_cnt_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_byte   = tx_byte_q;
    assign tx_start  = tx_start_q;
    assign grant     = grant_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a 10-cycle busy transmitter model.
module tb_uart_tx_arbiter;

    localparam int NR       = 4;
    localparam int HT       = 16;
    localparam int BUSY_LEN = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [8*NR-1:0] req_data  = '0;
    logic [NR-1:0]   req_last  = '0;
    logic [NR-1:0]   req_ready;
    logic [7:0]      tx_byte;
    logic            tx_start;
    logic            tx_busy;
    logic [NR-1:0]   grant;
    logic            timeout;

    int unsigned bcnt = 0;
    int n_checks = 0;
    int n_errors = 0;

    uart_tx_arbiter #(.NUM_REQ(NR), .HOLD_TIMEOUT(HT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .tx_byte   (tx_byte),
        .tx_start  (tx_start),
        .tx_busy   (tx_busy),
        .grant     (grant),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy for BUSY_LEN cycles starting the cycle after tx_start.
    always @(posedge clk) begin
        if (tx_start === 1'b1 && !rst) bcnt <= BUSY_LEN;
        else if (bcnt != 0) bcnt <= bcnt - 1;
    end
    assign tx_busy = (bcnt != 0);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] d, input bit l);
        req_valid[i]        = v;
        req_data[8*i +: 8]  = d;
        req_last[i]         = l;
    endtask

    task automatic wait_free();
        int n = 0;
        while (grant != 0 && n < 200) begin
            tick();
            n++;
        end
        check("free_wait", grant, 0);
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    logic [7:0] rr_b [4] = '{8'hA0, 8'hB1, 8'hC2, 8'hD3};
    logic [7:0] lk_b [3] = '{8'h41, 8'h42, 8'h43};
    logic [7:0] got_b [4];
    logic [NR-1:0] got_g [4];

    initial begin
        int starts, n, k;
        bit saw_busy, lock_bad, pb;

        // Reset with every requester valid
        req_valid = '1;
        req_last  = '1;
        req_data  = 32'h44332211;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_grant", grant, 0);
            check("rst_start", tx_start, 0);
            check("rst_ready", req_ready, 0);
            check("rst_timeout", timeout, 0);
            check("rst_byte", tx_byte, 8'h00);
        end
        rst = 1'b0;
        tick();
        check("first_grant", grant, 4'b0001);
        check("first_byte", tx_byte, 8'h11);
        check("first_start", tx_start, 1);
        req_valid = '0;
        wait_free();

        // Single byte with exact busy timing
        set_req(0, 1, 8'h46, 1);
        tick();
        check("sb_start", tx_start, 1);
        check("sb_ready", req_ready, 4'b0001);
        check("sb_byte", tx_byte, 8'h46);
        check("sb_grant", grant, 4'b0001);
        req_valid = '0;
        tick();
        check("sb_start_off", tx_start, 0);
        check("sb_ready_off", req_ready, 0);
        check("sb_busy_on", tx_busy, 1);
        check("sb_grant_hold", grant, 4'b0001);
        repeat (9) tick();
        check("sb_busy_last", tx_busy, 1);
        check("sb_grant_busy", grant, 4'b0001);
        tick();
        check("sb_busy_fell", tx_busy, 0);
        check("sb_grant_m", grant, 4'b0001);
        tick();
        check("sb_release", grant, 0);
        check("sb_byte_stable", tx_byte, 8'h46);

        // Round robin from ptr 0
        do_reset();
        req_data  = 32'hD3C2B1A0;
        req_last  = '1;
        req_valid = '1;
        starts = 0; n = 0; saw_busy = 0;
        while (starts < 6 && n < 500) begin
            tick();
            n++;
            if (tx_busy) saw_busy = 1;
            if (tx_start) begin
                check($sformatf("rr_grant%0d", starts), grant, 1 << (starts % 4));
                check($sformatf("rr_ready%0d", starts), req_ready, 1 << (starts % 4));
                check($sformatf("rr_byte%0d", starts), tx_byte, rr_b[starts % 4]);
                if (starts > 0) check("rr_busy_between", saw_busy, 1);
                saw_busy = 0;
                starts++;
            end
        end
        check("rr_count", starts, 6);
        req_valid = '0;
        wait_free();

        // Locked three-byte message from req1 while req2 waits
        do_reset();
        k = 0;
        set_req(1, 1, lk_b[0], 0);
        set_req(2, 1, 8'h55, 1);
        starts = 0; n = 0; lock_bad = 0;
        while (starts < 4 && n < 500) begin
            tick();
            n++;
            if (tx_start) begin
                got_b[starts] = tx_byte;
                got_g[starts] = grant;
                starts++;
            end
            if (starts >= 1 && starts < 3 && grant !== 4'b0010) lock_bad = 1;
            if (req_ready[1]) begin
                k++;
                if (k < 3) set_req(1, 1, lk_b[k], k == 2);
                else req_valid[1] = 1'b0;
            end
            if (req_ready[2]) req_valid[2] = 1'b0;
        end
        check("lk_count", starts, 4);
        check("lk_byte0", got_b[0], 8'h41);
        check("lk_byte1", got_b[1], 8'h42);
        check("lk_byte2", got_b[2], 8'h43);
        check("lk_byte3", got_b[3], 8'h55);
        check("lk_grant0", got_g[0], 4'b0010);
        check("lk_grant2", got_g[2], 4'b0010);
        check("lk_grant3", got_g[3], 4'b0100);
        check("lk_held", lock_bad, 0);
        wait_free();

        // Hold timeout: req0 stalls mid-message, req1 waiting
        do_reset();
        set_req(0, 1, 8'h77, 0);
        set_req(1, 1, 8'h88, 1);
        tick();
        check("to_grant0", grant, 4'b0001);
        check("to_start0", tx_start, 1);
        req_valid[0] = 1'b0;
        repeat (27) tick();
        check("to_early", timeout, 0);
        check("to_locked", grant, 4'b0001);
        tick();
        check("to_pulse", timeout, 1);
        check("to_release", grant, 0);
        tick();
        check("to_pulse_off", timeout, 0);
        check("to_next_grant", grant, 4'b0010);
        check("to_next_start", tx_start, 1);
        check("to_next_byte", tx_byte, 8'h88);
        req_valid = '0;
        wait_free();

        // Reset in DRAIN of req3's second byte
        do_reset();
        set_req(3, 1, 8'hA1, 0);
        tick();
        check("ml_grant3", grant, 4'b1000);
        set_req(3, 1, 8'hA2, 0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!tx_start && n < 100);
        check("ml_second_start", tx_start, 1);
        check("ml_second_byte", tx_byte, 8'hA2);
        set_req(3, 1, 8'hA3, 1);
        repeat (3) tick();
        check("ml_busy", tx_busy, 1);
        rst = 1'b1;
        set_req(0, 1, 8'h10, 1);
        tick();
        check("ml_rst_grant", grant, 0);
        check("ml_rst_start", tx_start, 0);
        check("ml_rst_ready", req_ready, 0);
        check("ml_rst_byte", tx_byte, 8'h00);
        check("ml_rst_timeout", timeout, 0);
        rst = 1'b0;
        n = 0; pb = 1'b1;
        do begin
            pb = tx_busy;
            tick();
            n++;
        end while (!tx_start && n < 100);
        check("ml_restart", tx_start, 1);
        check("ml_winner", grant, 4'b0001);
        check("ml_winner_byte", tx_byte, 8'h10);
        check("ml_waited_busy", pb, 0);
        check("ml_wait_len", n > 5, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1);
    end

endmodule
